skip_sub_serial: RTL and testbench
==================================

// Module: skip_sub_serial
// PURPOSE
// - Block-serial borrow-skip subtractor: diff = a - b - bin over WIDTH bits, BLK bits per clock.
// - Subtraction counterpart of the team's carry-skip adder.
// - Sits on a start/done handshake and serves datapath blocks that need wide subtraction without a wide ripple chain.
// - Per block it uses the ripple borrow, or skips the ripple and passes the incoming borrow straight through when every bit position propagates (a_i == b_i).
// PARAMETERS
// - WIDTH  16  operand/result width; must be a multiple of BLK (elaboration-time check fails otherwise)
// - BLK    4   bits processed per RUN cycle; NBLK = WIDTH/BLK
// PORTS
// - clk       in   1      rising-edge clock
// - rst       in   1      synchronous, active-high reset
// - start     in   1      request; accepted only when busy=0
// - a         in   WIDTH  minuend, sampled on accepting edge
// - b         in   WIDTH  subtrahend, sampled on accepting edge
// - bin       in   1      borrow-in, sampled on accepting edge
// - busy      out  1      1 while in RUN
// - done      out  1      one-cycle pulse: result valid
// - diff      out  WIDTH  a - b - bin mod 2^WIDTH
// - bout      out  1      borrow out of MSB (1 => unsigned a < b + bin)
// - ovf       out  1      signed overflow = borrow into MSB XOR borrow out of MSB
// - skip_cnt  out  $clog2(NBLK+1)  number of blocks that took the skip path
// BEHAVIOUR
// - Single clock, synchronous active-high reset. On rst: FSM=IDLE; busy, done, diff, bout, ovf and skip_cnt = 0.
// - FSM states:
//   - IDLE: on start & !busy, latch a, b and bin; blk_idx=0; borrow=bin; clear diff and skip_cnt; go to RUN.
//   - RUN: each cycle process slice [blk_idx*BLK +: BLK].
//     - d_i = a_i ^ b_i ^ bw_i; bw_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & bw_i).
//     - Block propagate P = AND over (a_i == b_i). If P=1, block borrow-out = block borrow-in (skip) and skip_cnt += 1. Otherwise it is the ripple result. Both paths must agree arithmetically.
//     - Write the slice into diff; blk_idx++. After slice NBLK-1: capture bout and ovf, go to IDLE, pulse done on the next cycle.
// - Latency: start edge -> done high = NBLK+1 cycles (5 at defaults). busy is high for exactly NBLK cycles.
// - start while busy=1: ignored, with no effect on operands or state.
// - start in the done cycle: accepted, because busy=0. That allows back-to-back operations every NBLK+1 cycles.
// - diff, bout, ovf and skip_cnt hold their values from done until the next accepted start.
//   - Partial diff is visible during RUN and is undefined for consumers.
// - rst mid-RUN: abort, return to IDLE and zero all outputs. No done pulse for the aborted operation.
// - Width rules: borrow chain is 1 bit. skip_cnt saturates naturally (max NBLK). All arithmetic is unsigned except ovf.
// STRUCTURE
// - Shared package skip_sub_pkg: state enum {IDLE, RUN}; default BLK; helper function for NBLK/skip_cnt width.
// - One sub-module: skip_sub_blk, a combinational BLK-bit slice.
//   - Inputs: a_blk, b_blk, bw_in.
//   - Outputs: d_blk, bw_out, skip, bw_msb_in (the latter feeds ovf).
// - Top holds the FSM, operand registers, blk_idx counter, borrow register and output registers.
// TESTING (WIDTH=16, BLK=4)
// - a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0, skip_cnt=3; done exactly 5 cycles after the start edge.
// - a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, skip_cnt=3 (borrow skips blocks 1..3).
// - a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1, skip_cnt=2.
// - a=b=0xABCD, bin=1 -> diff=0xFFFF, bout=1, ovf=0, skip_cnt=4 (all-skip path).
// - start pulsed at cycles 2 and 3 of RUN with other operands -> ignored, first result unchanged.
//   - Then rst at RUN cycle 2 of a new op -> busy=0, no done, all outputs 0.
// - Back-to-back: 2nd start in the done cycle -> accepted, 2nd done 5 cycles later.
//   - Random 1000-op regression vs a-b-bin reference model; skip_cnt matches the per-block a==b count.

Source files
------------

// File: rtl/skip_sub_pkg.sv
// Shared types and sizing helpers for the block-serial borrow-skip subtractor.
package skip_sub_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int DEF_BLK = 4;

    // Width able to hold 0..nblk; also wide enough to index blocks 0..nblk-1.
    function automatic int cnt_w(input int nblk);
        return (nblk < 1) ? 1 : $clog2(nblk + 1);
    endfunction

endpackage

// File: rtl/skip_sub_blk.sv
// Combinational BLK-bit subtract slice with borrow-skip when every bit propagates.
module skip_sub_blk
    import skip_sub_pkg::*;
#(
    parameter int BLK = DEF_BLK
) (
    input  logic [BLK-1:0] a_blk,
    input  logic [BLK-1:0] b_blk,
    input  logic           bw_in,
    output logic [BLK-1:0] d_blk,
    output logic           bw_out,
    output logic           skip,
    output logic           bw_msb_in
);

    logic [BLK:0] bw;

    assign bw[0] = bw_in;

    for (genvar i = 0; i < BLK; i++) begin : g_bit
        assign d_blk[i]  = a_blk[i] ^ b_blk[i] ^ bw[i];
        assign bw[i+1]   = (~a_blk[i] & b_blk[i]) | (~(a_blk[i] ^ b_blk[i]) & bw[i]);
    end

    // All positions equal: the ripple would just carry bw_in through, so bypass it.
    assign skip      = &(~(a_blk ^ b_blk));
    assign bw_out    = skip ? bw_in : bw[BLK];
    assign bw_msb_in = bw[BLK-1];

endmodule

// File: rtl/skip_sub_serial.sv
// Block-serial borrow-skip subtractor: diff = a - b - bin, BLK bits per RUN cycle.
module skip_sub_serial
    import skip_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = DEF_BLK
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic                          bin,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              diff,
    output logic                          bout,
    output logic                          ovf,
    output logic [cnt_w(WIDTH/BLK)-1:0]   skip_cnt
);

    localparam int NBLK = WIDTH / BLK;
    localparam int CW   = cnt_w(NBLK);

    if ((WIDTH % BLK) != 0 || NBLK < 1) begin : g_chk
        $error("skip_sub_serial: WIDTH must be a positive multiple of BLK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa, opb;
    logic             bw;
    logic [CW-1:0]    blk_idx;
    logic             last;

    logic [BLK-1:0]   a_blk, b_blk, d_blk;
    logic             bw_out, skip, bw_msb_in;

    assign busy  = (state_q == RUN);
    assign last  = (blk_idx == CW'(NBLK - 1));
    assign a_blk = opa[int'(blk_idx)*BLK +: BLK];
    assign b_blk = opb[int'(blk_idx)*BLK +: BLK];

    skip_sub_blk #(.BLK(BLK)) u_blk (
        .a_blk     (a_blk),
        .b_blk     (b_blk),
        .bw_in     (bw),
        .d_blk     (d_blk),
        .bw_out    (bw_out),
        .skip      (skip),
        .bw_msb_in (bw_msb_in)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opa      <= '0;
            opb      <= '0;
            bw       <= 1'b0;
            blk_idx  <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            skip_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    opa      <= a;
                    opb      <= b;
                    bw       <= bin;
                    blk_idx  <= '0;
                    diff     <= '0;
                    bout     <= 1'b0;
                    ovf      <= 1'b0;
                    skip_cnt <= '0;
                end
                RUN: begin
                    diff[int'(blk_idx)*BLK +: BLK] <= d_blk;
                    bw       <= bw_out;
                    skip_cnt <= skip_cnt + CW'(skip);
                    blk_idx  <= blk_idx + 1'b1;
                    // Done registers with the final slice, so it is seen in the first IDLE cycle.
                    if (last) begin
                        bout <= bw_out;
                        ovf  <= bw_msb_in ^ bw_out;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skip_sub_serial.sv
// Self-checking bench for skip_sub_serial: directed corner cases plus random regression.
module tb_skip_sub_serial;

    localparam int W    = 16;
    localparam int BK   = 4;
    localparam int NB   = W / BK;
    localparam int MAXC = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a, b;
    logic          bin;
    logic          busy, done;
    logic [W-1:0]  diff;
    logic          bout, ovf;
    logic [2:0]    skip_cnt;

    int checks = 0;
    int errors = 0;
    int cyc;

    skip_sub_serial #(.WIDTH(W), .BLK(BK)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf),
        .skip_cnt (skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole word.
    task automatic check_res(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                             input logic rbin);
        int ua, ub, ud, sa, sb, sd, sk;
        ua = int'(ra);
        ub = int'(rb);
        ud = ua - ub - int'(rbin);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        sd = sa - sb - int'(rbin);
        sk = 0;
        for (int k = 0; k < NB; k++)
            if (((ua >> (k*BK)) & 15) == ((ub >> (k*BK)) & 15)) sk++;
        chk({tag, ".diff"}, 32'(diff), 32'(ud & 16'hFFFF));
        chk({tag, ".bout"}, 32'(bout), 32'(ud < 0));
        chk({tag, ".ovf"},  32'(ovf),  32'(sd < -32768 || sd > 32767));
        chk({tag, ".skip"}, 32'(skip_cnt), 32'(sk));
    endtask

    // Called at a negedge with the DUT idle (or in its done cycle); returns after the accept edge.
    task automatic start_op(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nbin);
        a = na; b = nb; bin = nbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
        cyc = 1;
    endtask

    // Walk RUN cycles until done; optional busy checks and ignored-start injection.
    task automatic wait_done(input string tag, input bit chk_busy, input bit inject);
        while (!done && cyc <= MAXC) begin
            if (chk_busy) chk({tag, ".busy"}, 32'(busy), 32'(cyc <= NB));
            if (inject && (cyc == 2 || cyc == 3)) begin
                start = 1'b1; a = $urandom; b = $urandom; bin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, ".lat"}, 32'(cyc), 32'(NB + 1));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.diff", 32'(diff), 32'd0);
        chk("rst.flags", {29'd0, bout, ovf, 1'b0}, 32'd0);
        chk("rst.skip", 32'(skip_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with spelled-out expectations.
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_done("d0", 1'b1, 1'b0);
        chk("d0.diff_c", 32'(diff), 32'h1000);
        chk("d0.skip_c", 32'(skip_cnt), 32'd3);
        check_res("d0", 16'h1234, 16'h0234, 1'b0);
        @(negedge clk);
        chk("d0.done_pulse", 32'(done), 32'd0);
        chk("d0.hold", 32'(diff), 32'h1000);

        start_op(16'h0000, 16'h0001, 1'b0);
        wait_done("d1", 1'b0, 1'b0);
        chk("d1.c", {15'd0, diff, bout}, {15'd0, 16'hFFFF, 1'b1});
        check_res("d1", 16'h0000, 16'h0001, 1'b0);
        @(negedge clk);

        start_op(16'h8000, 16'h0001, 1'b0);
        wait_done("d2", 1'b0, 1'b0);
        chk("d2.c", {12'd0, diff, bout, ovf, skip_cnt}, {12'd0, 16'h7FFF, 1'b0, 1'b1, 3'd2});
        check_res("d2", 16'h8000, 16'h0001, 1'b0);
        @(negedge clk);

        start_op(16'hABCD, 16'hABCD, 1'b1);
        wait_done("d3", 1'b0, 1'b0);
        chk("d3.c", {12'd0, diff, bout, ovf, skip_cnt}, {12'd0, 16'hFFFF, 1'b1, 1'b0, 3'd4});
        check_res("d3", 16'hABCD, 16'hABCD, 1'b1);
        @(negedge clk);

        // Starts during RUN must not disturb the operation in flight.
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_done("ign", 1'b1, 1'b1);
        check_res("ign", 16'h1234, 16'h0234, 1'b0);
        @(negedge clk);

        // Reset mid-RUN: abort, clear outputs, no done.
        start_op(16'h5A5A, 16'h1234, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.outs", {13'd0, diff, bout, ovf, skip_cnt}, 32'd0);
        cyc = 0;
        repeat (NB + 2) begin
            if (done) cyc++;
            @(negedge clk);
        end
        chk("abort.nodone", 32'(cyc), 32'd0);

        // Back-to-back: second start issued in the done cycle.
        start_op(16'hFFFF, 16'h0F0F, 1'b0);
        wait_done("bb0", 1'b0, 1'b0);
        check_res("bb0", 16'hFFFF, 16'h0F0F, 1'b0);
        start_op(16'h0F0F, 16'hFFFF, 1'b1);
        wait_done("bb1", 1'b1, 1'b0);
        check_res("bb1", 16'h0F0F, 16'hFFFF, 1'b1);

        // Random regression, chained back-to-back; b shares random nibbles with a to exercise skips.
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = ra;
            for (int k = 0; k < NB; k++)
                if ($urandom_range(1, 0) == 1) rb[k*BK +: BK] = BK'($urandom);
            rbin = 1'($urandom);
            start_op(ra, rb, rbin);
            wait_done("rnd", 1'b0, 1'b0);
            check_res("rnd", ra, rb, rbin);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
